// File: rtl/z_to_z_engine_pkg.sv
// Shared types and the fixed-point saturating rescale helper for the z-to-z engine.
// Supports element widths up to MAX_DATA_SIZE bits.
package z_to_z_pkg;

    localparam int unsigned MAX_DATA_SIZE = 32;

    typedef enum logic [1:0] {
        SRC_COST  = 2'd0,
        SRC_DENSE = 2'd1,
        SRC_PREV  = 2'd2,
        SRC_RSVD  = 2'd3
    } src_sel_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef struct packed {
        logic [MAX_DATA_SIZE-1:0] value;
        logic                     ovf;
    } sat_res_t;

    // The arithmetic shift of a signed product floors toward minus infinity.
    function automatic sat_res_t sat_shift(input longint product,
                                           input int unsigned frac_bits,
                                           input int unsigned data_size);
        longint   shifted;
        longint   lim_hi;
        longint   lim_lo;
        sat_res_t r;
        shifted = product >>> frac_bits;
        lim_hi  = (longint'(1) <<< (data_size - 1)) - longint'(1);
        lim_lo  = -lim_hi - longint'(1);
        r.ovf   = 1'b0;
        if (shifted > lim_hi) begin
            r.value = lim_hi[MAX_DATA_SIZE-1:0];
            r.ovf   = 1'b1;
        end else if (shifted < lim_lo) begin
            r.value = lim_lo[MAX_DATA_SIZE-1:0];
            r.ovf   = 1'b1;
        end else begin
            r.value = shifted[MAX_DATA_SIZE-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/z_to_z_engine_if.sv
// Operand, result and handshake bundle between the backprop stack and the z-to-z engine.
interface z_to_z_engine_if #(
    parameter int unsigned DATA_SIZE = 16,
    parameter int unsigned SIZE      = 3
);
    logic                      start_new_layer;
    logic [1:0]                src_sel;
    logic [DATA_SIZE*SIZE-1:0] diff_act;
    logic [DATA_SIZE*SIZE-1:0] diff_cost;
    logic [DATA_SIZE*SIZE-1:0] diff_dense;
    logic [DATA_SIZE*SIZE-1:0] diff_z_to_z;
    logic                      busy;
    logic                      done;
    logic                      out_valid;
    logic                      sat;

    modport master (
        output start_new_layer, src_sel, diff_act, diff_cost, diff_dense,
        input  diff_z_to_z, busy, done, out_valid, sat
    );

    modport slave (
        input  start_new_layer, src_sel, diff_act, diff_cost, diff_dense,
        output diff_z_to_z, busy, done, out_valid, sat
    );
endinterface

// File: rtl/z_to_z_lane_mul.sv
// One combinational lane: signed multiply, rescale by FRAC_BITS, saturate to DATA_SIZE.
module z_to_z_lane_mul
    import z_to_z_pkg::*;
#(
    parameter int unsigned DATA_SIZE = 16,
    parameter int unsigned FRAC_BITS = 8
) (
    input  logic [DATA_SIZE-1:0] a,
    input  logic [DATA_SIZE-1:0] b,
    output logic [DATA_SIZE-1:0] y,
    output logic                 ovf
);
    logic signed [2*DATA_SIZE-1:0] product;
    sat_res_t                      res;

    always_comb begin
        product = $signed(a) * $signed(b);
        res     = sat_shift(longint'(product), FRAC_BITS, DATA_SIZE);
        y       = res.value[DATA_SIZE-1:0];
        ovf     = res.ovf;
    end

    if (DATA_SIZE < MAX_DATA_SIZE) begin : g_hi
        logic unused_hi;
        assign unused_hi = ^res.value[MAX_DATA_SIZE-1:DATA_SIZE];
    end
endmodule

// File: rtl/z_to_z_engine.sv
// Error-term engine: diff_z_to_z[i] = diff_act[i] * src[i], LANES multipliers time-shared
// over SIZE elements in SIZE/LANES beats, with saturation and a done/out_valid handshake.
module z_to_z_engine
    import z_to_z_pkg::*;
#(
    parameter int unsigned DATA_SIZE = 16,
    parameter int unsigned FRAC_BITS = DATA_SIZE / 2,
    parameter int unsigned SIZE      = 3,
    parameter int unsigned LANES     = 1
) (
    input  logic          clk,
    input  logic          rst,
    z_to_z_engine_if.slave bus
);
    localparam int unsigned BEATS = SIZE / LANES;
    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    if (LANES == 0 || (SIZE % LANES) != 0) begin : g_bad_lanes
        $error("z_to_z_engine: SIZE must be a non-zero multiple of LANES");
    end
    if (DATA_SIZE > MAX_DATA_SIZE) begin : g_bad_width
        $error("z_to_z_engine: DATA_SIZE exceeds MAX_DATA_SIZE");
    end

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   beat_q;
    logic               capture, last_beat, running;
    logic               done_q, out_valid_q, sat_q;

    // Operand/result storage is laid out [beat][lane]; element i = beat*LANES + lane.
    logic [DATA_SIZE-1:0] act_q [BEATS][LANES];
    logic [DATA_SIZE-1:0] src_q [BEATS][LANES];
    logic [DATA_SIZE-1:0] res_q [BEATS][LANES];

    logic [DATA_SIZE-1:0] lane_a [LANES];
    logic [DATA_SIZE-1:0] lane_b [LANES];
    logic [DATA_SIZE-1:0] lane_y [LANES];
    logic [LANES-1:0]     lane_ovf;

    assign running = (state_q == ST_RUN);

    always_comb begin
        state_d   = state_q;
        capture   = 1'b0;
        last_beat = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start_new_layer) begin
                    capture = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (beat_q == LAST_BEAT) begin
                    last_beat = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            beat_q      <= '0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            sat_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= last_beat;
            if (capture) begin
                beat_q      <= '0;
                out_valid_q <= 1'b0;
                sat_q       <= 1'b0;
            end else if (running) begin
                sat_q <= sat_q | (|lane_ovf);
                if (last_beat) begin
                    beat_q      <= '0;
                    out_valid_q <= 1'b1;
                end else begin
                    beat_q <= beat_q + 1'b1;
                end
            end
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign lane_a[l] = act_q[beat_q][l];
        assign lane_b[l] = src_q[beat_q][l];

        z_to_z_lane_mul #(
            .DATA_SIZE (DATA_SIZE),
            .FRAC_BITS (FRAC_BITS)
        ) u_mul (
            .a   (lane_a[l]),
            .b   (lane_b[l]),
            .y   (lane_y[l]),
            .ovf (lane_ovf[l])
        );
    end

    for (genvar b = 0; b < BEATS; b++) begin : g_beat
        for (genvar l = 0; l < LANES; l++) begin : g_elem
            localparam int unsigned IDX = b * LANES + l;
            localparam int unsigned MSB = DATA_SIZE * (SIZE - IDX) - 1;
            logic [DATA_SIZE-1:0] src_pick;

            always_comb begin
                src_pick = bus.diff_dense[MSB -: DATA_SIZE];
                case (src_sel_e'(bus.src_sel))
                    SRC_COST: src_pick = bus.diff_cost[MSB -: DATA_SIZE];
                    SRC_PREV: src_pick = res_q[b][l];
                    default:  src_pick = bus.diff_dense[MSB -: DATA_SIZE];
                endcase
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    act_q[b][l] <= '0;
                    src_q[b][l] <= '0;
                    res_q[b][l] <= '0;
                end else begin
                    if (capture) begin
                        act_q[b][l] <= bus.diff_act[MSB -: DATA_SIZE];
                        src_q[b][l] <= src_pick;
                    end
                    if (running && beat_q == CNT_W'(b)) begin
                        res_q[b][l] <= lane_y[l];
                    end
                end
            end

            assign bus.diff_z_to_z[MSB -: DATA_SIZE] = res_q[b][l];
        end
    end

    assign bus.busy      = running;
    assign bus.done      = done_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sat       = sat_q;
endmodule

// File: tb/tb_z_to_z_engine.sv
// Self-checking bench: serial (LANES=1) and fully parallel (LANES=3) engines against a
// floor-divide/clamp reference model, with directed corner cases and random operands.
module tb_z_to_z_engine;
    localparam int unsigned DS = 16;
    localparam int unsigned FB = 8;
    localparam int unsigned SZ = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    z_to_z_engine_if #(.DATA_SIZE(DS), .SIZE(SZ)) bus1 ();
    z_to_z_engine_if #(.DATA_SIZE(DS), .SIZE(SZ)) bus3 ();

    z_to_z_engine #(.DATA_SIZE(DS), .FRAC_BITS(FB), .SIZE(SZ), .LANES(1)) dut1 (
        .clk (clk), .rst (rst), .bus (bus1)
    );
    z_to_z_engine #(.DATA_SIZE(DS), .FRAC_BITS(FB), .SIZE(SZ), .LANES(3)) dut3 (
        .clk (clk), .rst (rst), .bus (bus3)
    );

    int checks   = 0;
    int failures = 0;

    logic [15:0] m_prev [SZ];
    logic [47:0] m_res;
    logic        m_sat;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Real-valued view: product / 2^FB rounded toward minus infinity, then clamped.
    function automatic void model_elem(input logic [15:0] a, input logic [15:0] b,
                                       output logic [15:0] y, output logic ovf);
        longint p;
        longint q;
        p   = longint'($signed(a)) * longint'($signed(b));
        q   = p / 256;
        if (p < 0 && (p % 256) != 0) q = q - 1;
        ovf = 1'b0;
        if (q > 32767) begin
            y = 16'h7FFF; ovf = 1'b1;
        end else if (q < -32768) begin
            y = 16'h8000; ovf = 1'b1;
        end else begin
            y = q[15:0];
        end
    endfunction

    function automatic logic [15:0] elem(input logic [47:0] v, input int i);
        return v[16*(SZ-i)-1 -: 16];
    endfunction

    function automatic logic [47:0] pack3(input logic [15:0] e0, input logic [15:0] e1,
                                          input logic [15:0] e2);
        return {e0, e1, e2};
    endfunction

    task automatic compute_model(input logic [47:0] act, input logic [47:0] cost,
                                 input logic [47:0] dense, input logic [1:0] sel);
        logic [15:0] s;
        logic [15:0] y;
        logic        o;
        m_sat = 1'b0;
        for (int i = 0; i < int'(SZ); i++) begin
            if (sel == 2'd0)      s = elem(cost, i);
            else if (sel == 2'd2) s = m_prev[i];
            else                  s = elem(dense, i);
            model_elem(elem(act, i), s, y, o);
            m_res[16*(SZ-i)-1 -: 16] = y;
            m_sat = m_sat | o;
        end
        for (int i = 0; i < int'(SZ); i++) m_prev[i] = elem(m_res, i);
    endtask

    task automatic drive(input logic [47:0] act, input logic [47:0] cost,
                         input logic [47:0] dense, input logic [1:0] sel);
        bus1.diff_act = act; bus1.diff_cost = cost; bus1.diff_dense = dense; bus1.src_sel = sel;
        bus3.diff_act = act; bus3.diff_cost = cost; bus3.diff_dense = dense; bus3.src_sel = sel;
    endtask

    task automatic scramble_inputs();
        drive({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
              2'($urandom_range(0, 3)));
    endtask

    task automatic run_op(input string tag, input logic [47:0] act, input logic [47:0] cost,
                          input logic [47:0] dense, input logic [1:0] sel, input bit extra_start);
        int n1, n3, lat1, lat3;
        n1 = 0; n3 = 0; lat1 = -1; lat3 = -1;
        @(negedge clk);
        drive(act, cost, dense, sel);
        compute_model(act, cost, dense, sel);
        bus1.start_new_layer = 1'b1;
        bus3.start_new_layer = 1'b1;
        @(posedge clk); #1;
        check({tag, ".busy1_e0"}, 64'(bus1.busy), 64'd1);
        check({tag, ".ov1_e0"}, 64'(bus1.out_valid), 64'd0);
        @(negedge clk);
        bus1.start_new_layer = extra_start;
        bus3.start_new_layer = 1'b0;
        scramble_inputs();
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            if (bus1.done) begin n1++; lat1 = c; end
            if (bus3.done) begin n3++; lat3 = c; end
            if (c == 2) check({tag, ".busy1_mid"}, 64'(bus1.busy), 64'd1);
            if (c == 3) check({tag, ".busy1_end"}, 64'(bus1.busy), 64'd0);
            @(negedge clk);
            bus1.start_new_layer = 1'b0;
        end
        check({tag, ".ndone1"}, 64'(n1), 64'd1);
        check({tag, ".lat1"}, 64'(lat1), 64'd3);
        check({tag, ".ndone3"}, 64'(n3), 64'd1);
        check({tag, ".lat3"}, 64'(lat3), 64'd1);
        check({tag, ".res1"}, 64'(bus1.diff_z_to_z), 64'(m_res));
        check({tag, ".res3"}, 64'(bus3.diff_z_to_z), 64'(m_res));
        check({tag, ".sat1"}, 64'(bus1.sat), 64'(m_sat));
        check({tag, ".sat3"}, 64'(bus3.sat), 64'(m_sat));
        check({tag, ".ov1"}, 64'(bus1.out_valid), 64'd1);
        check({tag, ".ov3"}, 64'(bus3.out_valid), 64'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".z1"}, 64'({bus1.diff_z_to_z, bus1.busy, bus1.done, bus1.out_valid, bus1.sat}), 64'd0);
        check({tag, ".z3"}, 64'({bus3.diff_z_to_z, bus3.busy, bus3.done, bus3.out_valid, bus3.sat}), 64'd0);
    endtask

    initial begin
        int nd;
        logic [47:0] ra, rc, rd;
        rst = 1'b1;
        bus1.start_new_layer = 1'b0;
        bus3.start_new_layer = 1'b0;
        drive('0, '0, '0, 2'd0);
        for (int i = 0; i < int'(SZ); i++) m_prev[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        run_op("basic", pack3(16'h0180, 16'h0100, 16'h0080),
               pack3(16'h0200, 16'h0300, 16'h0400), '0, 2'd0, 1'b0);
        check("basic.const", 64'(bus1.diff_z_to_z), 64'h0300_0300_0200);

        run_op("chain", pack3(16'h0080, 16'h0080, 16'h0080), '0, '0, 2'd2, 1'b0);
        check("chain.const", 64'(bus1.diff_z_to_z), 64'h0180_0180_0100);

        run_op("sign", pack3(16'hFE80, 16'hFFFF, 16'h0100), '0,
               pack3(16'h0200, 16'h0001, 16'h0300), 2'd1, 1'b0);
        check("sign.const", 64'(bus1.diff_z_to_z), 64'hFD00_FFFF_0300);

        run_op("satur", pack3(16'h6400, 16'h9C00, 16'h0100),
               pack3(16'h6400, 16'h6400, 16'h0100), '0, 2'd0, 1'b0);
        check("satur.const", 64'({bus1.diff_z_to_z, bus1.sat}), 64'({48'h7FFF_8000_0100, 1'b1}));

        run_op("busyprot", pack3(16'h0040, 16'hFF00, 16'h0200), '0,
               pack3(16'h0800, 16'h0123, 16'hF000), 2'd3, 1'b1);

        // Abort one beat into a run: outputs clear asynchronously, no done follows.
        @(negedge clk);
        drive(pack3(16'h0100, 16'h0100, 16'h0100), pack3(16'h0500, 16'h0600, 16'h0700), '0, 2'd0);
        bus1.start_new_layer = 1'b1;
        bus3.start_new_layer = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        bus1.start_new_layer = 1'b0;
        bus3.start_new_layer = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        rst = 1'b0;
        nd = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            nd += int'(bus1.done) + int'(bus3.done);
        end
        check("midrst.nodone", 64'(nd), 64'd0);
        for (int i = 0; i < int'(SZ); i++) m_prev[i] = '0;

        run_op("postrst", pack3(16'h0300, 16'hFD00, 16'h0010), '0,
               pack3(16'h0200, 16'h0200, 16'h8000), 2'd1, 1'b0);

        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < int'(SZ); i++) begin
                ra[16*(SZ-i)-1 -: 16] = ($urandom_range(0, 1) == 1) ? 16'($urandom)
                                                                    : 16'($urandom_range(0, 16'h0800) - 16'h0400);
                rc[16*(SZ-i)-1 -: 16] = 16'($urandom);
                rd[16*(SZ-i)-1 -: 16] = 16'($urandom_range(0, 16'h1000) - 16'h0800);
            end
            run_op($sformatf("rand%0d", k), ra, rc, rd, 2'($urandom_range(0, 3)), k[0]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
